// File: rtl/elevator_shaft_model_pkg.sv
// Shared codes for the elevator shaft model: motor commands, floor codes,
// shaft state encodings and the floor-to-sensor decode.
package elevator_shaft_model_pkg;

    localparam logic [1:0] AC_STOP    = 2'b00;
    localparam logic [1:0] AC_UP      = 2'b01;
    localparam logic [1:0] AC_DOWN    = 2'b10;
    localparam logic [1:0] AC_ILLEGAL = 2'b11;

    localparam logic [1:0] FLOOR_1 = 2'd1;
    localparam logic [1:0] FLOOR_2 = 2'd2;
    localparam logic [1:0] FLOOR_3 = 2'd3;

    typedef enum logic [1:0] {
        ST_AT_FLOOR  = 2'd0,
        ST_MOVE_UP   = 2'd1,
        ST_MOVE_DOWN = 2'd2,
        ST_FAULT     = 2'd3
    } shaft_state_e;

    // One-hot {s3,s2,s1}; anything outside 1..3 lights no sensor.
    function automatic logic [2:0] floor_sensor(input logic [1:0] floor_code);
        logic [2:0] onehot;
        onehot = 3'b000;
        case (floor_code)
            FLOOR_1: onehot = 3'b001;
            FLOOR_2: onehot = 3'b010;
            FLOOR_3: onehot = 3'b100;
            default: onehot = 3'b000;
        endcase
        return onehot;
    endfunction

endpackage

// File: rtl/elevator_shaft_model_timer.sv
// Travel timer between adjacent floors: clear, mirror on reversal, count on
// motion cycles, saturating so it can never wrap.
module elevator_shaft_model_timer #(
    parameter int TRAVEL_CYCLES = 5
) (
    input  logic clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_mirror,
    input  logic i_enable,
    output logic o_step_done,
    output logic o_mirror_done
);

    localparam int W = $clog2(TRAVEL_CYCLES) + 1;
    localparam logic [W-1:0] LAST    = W'(TRAVEL_CYCLES - 1);
    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_mirror) begin
            r_count <= (r_count > LAST) ? '0 : LAST - r_count;
        end else if (i_enable && (r_count != CNT_MAX)) begin
            r_count <= r_count + W'(1);
        end
    end

    // The step that moves the count onto LAST is the arrival step.
    assign o_step_done   = (r_count >= LAST - W'(1));
    assign o_mirror_done = (r_count == '0);

endmodule

// File: rtl/elevator_shaft_model.sv
// Car/shaft model: consumes motor command and door state, emits one-cycle
// floor sensor pulses, tracks the last floor reached and latches illegal use.
module elevator_shaft_model
    import elevator_shaft_model_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 5,
    parameter int START_FLOOR   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] ac,
    input  logic       doorOpen,
    output logic       s1,
    output logic       s2,
    output logic       s3,
    output logic [1:0] pos_floor,
    output logic       moving,
    output logic       fault
);

    localparam logic [1:0] START_POS = 2'(START_FLOOR);

    shaft_state_e r_state;
    logic [1:0]   r_pos;
    logic [1:0]   r_target;
    logic [1:0]   r_far;
    logic [2:0]   r_sens;
    logic         r_moving;
    logic         r_fault;

    logic       w_is_up;
    logic       w_is_down;
    logic       w_cmd_fault;
    logic       w_overtravel;
    logic       w_fault_now;
    logic       w_same_dir;
    logic       w_reverse;
    logic       w_step_done;
    logic       w_mirror_done;
    logic       w_tmr_clear;
    logic       w_tmr_mirror;
    logic       w_tmr_enable;
    logic [1:0] w_other_end;

    assign w_is_up   = (ac == AC_UP);
    assign w_is_down = (ac == AC_DOWN);

    assign w_cmd_fault  = (ac == AC_ILLEGAL) || (doorOpen && (w_is_up || w_is_down));
    assign w_overtravel = (r_state == ST_AT_FLOOR) &&
                          ((w_is_up && (r_pos == FLOOR_3)) || (w_is_down && (r_pos == FLOOR_1)));
    assign w_fault_now  = (r_state != ST_FAULT) && (w_cmd_fault || w_overtravel);

    assign w_same_dir = ((r_state == ST_MOVE_UP) && w_is_up) ||
                        ((r_state == ST_MOVE_DOWN) && w_is_down);
    assign w_reverse  = ((r_state == ST_MOVE_UP) && w_is_down) ||
                        ((r_state == ST_MOVE_DOWN) && w_is_up);

    // pos_floor stays on the departure floor during travel, so the two ends
    // of the current hop are r_pos and r_far; a reversal swaps the target.
    assign w_other_end = (r_target == r_pos) ? r_far : r_pos;

    assign w_tmr_clear  = (r_state == ST_AT_FLOOR) && !w_fault_now && (w_is_up || w_is_down);
    assign w_tmr_mirror = w_reverse && !w_fault_now;
    assign w_tmr_enable = w_same_dir && !w_fault_now;

    elevator_shaft_model_timer #(
        .TRAVEL_CYCLES(TRAVEL_CYCLES)
    ) u_timer (
        .clk           (clk),
        .i_rst         (rst),
        .i_clear       (w_tmr_clear),
        .i_mirror      (w_tmr_mirror),
        .i_enable      (w_tmr_enable),
        .o_step_done   (w_step_done),
        .o_mirror_done (w_mirror_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_AT_FLOOR;
            r_pos    <= START_POS;
            r_target <= START_POS;
            r_far    <= START_POS;
            r_sens   <= 3'b000;
            r_moving <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_sens   <= 3'b000;
            r_moving <= 1'b0;
            if (w_fault_now) begin
                r_state <= ST_FAULT;
                r_fault <= 1'b1;
            end else begin
                case (r_state)
                    ST_AT_FLOOR: begin
                        if (w_is_up) begin
                            r_state  <= ST_MOVE_UP;
                            r_target <= r_pos + 2'd1;
                            r_far    <= r_pos + 2'd1;
                            r_moving <= 1'b1;
                        end else if (w_is_down) begin
                            r_state  <= ST_MOVE_DOWN;
                            r_target <= r_pos - 2'd1;
                            r_far    <= r_pos - 2'd1;
                            r_moving <= 1'b1;
                        end
                    end
                    ST_MOVE_UP, ST_MOVE_DOWN: begin
                        if (w_same_dir) begin
                            r_moving <= 1'b1;
                            if (w_step_done) begin
                                r_state <= ST_AT_FLOOR;
                                r_pos   <= r_target;
                                r_sens  <= floor_sensor(r_target);
                            end
                        end else if (w_reverse) begin
                            r_moving <= 1'b1;
                            // Reversing at timer 0 means the car never left the floor zone.
                            if (w_mirror_done) begin
                                r_state <= ST_AT_FLOOR;
                                r_pos   <= w_other_end;
                                r_sens  <= floor_sensor(w_other_end);
                            end else begin
                                r_state  <= (r_state == ST_MOVE_UP) ? ST_MOVE_DOWN : ST_MOVE_UP;
                                r_target <= w_other_end;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign s1        = r_sens[0];
    assign s2        = r_sens[1];
    assign s3        = r_sens[2];
    assign pos_floor = r_pos;
    assign moving    = r_moving;
    assign fault     = r_fault;

endmodule

// File: tb/tb_elevator_shaft_model.sv
// Directed bench for elevator_shaft_model (TRAVEL_CYCLES=4, START_FLOOR=1):
// stimulus pushes the expected post-edge outputs, a monitor pops and compares.
module tb_elevator_shaft_model;

    localparam logic [1:0] STOP = 2'b00;
    localparam logic [1:0] UP   = 2'b01;
    localparam logic [1:0] DN   = 2'b10;
    localparam logic [1:0] ILL  = 2'b11;
    localparam logic [2:0] S0   = 3'b000;
    localparam logic [2:0] S1   = 3'b001;
    localparam logic [2:0] S2   = 3'b010;
    localparam logic [2:0] S3   = 3'b100;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] ac;
    logic       doorOpen;
    logic       s1, s2, s3;
    logic [1:0] pos_floor;
    logic       moving;
    logic       fault;

    always #5 clk = ~clk;

    elevator_shaft_model #(
        .TRAVEL_CYCLES(4),
        .START_FLOOR  (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ac        (ac),
        .doorOpen  (doorOpen),
        .s1        (s1),
        .s2        (s2),
        .s3        (s3),
        .pos_floor (pos_floor),
        .moving    (moving),
        .fault     (fault)
    );

    typedef struct packed {
        logic [2:0] s;
        logic [1:0] pos;
        logic       mov;
        logic       flt;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    exp_t  mon_e;
    string mon_nm;

    task automatic check(input string nm, input string fld, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s.%s actual=%0d required=%0d", nm, fld, act, req);
    endtask

    // Inputs are applied, then the next rising edge must produce the expectation.
    task automatic step(input logic r, input logic [1:0] a, input logic d,
                        input logic [2:0] es, input logic [1:0] ep,
                        input logic em, input logic ef, input string nm);
        exp_t e;
        rst      = r;
        ac       = a;
        doorOpen = d;
        e.s   = es;
        e.pos = ep;
        e.mov = em;
        e.flt = ef;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (exp_q.size() > 0) begin
                mon_e  = exp_q.pop_front();
                mon_nm = name_q.pop_front();
                @(negedge clk);
                $display("%0t %s: s3s2s1=%b%b%b pos=%0d moving=%b fault=%b",
                         $time, mon_nm, s3, s2, s1, pos_floor, moving, fault);
                check(mon_nm, "sensors", int'({s3, s2, s1}), int'(mon_e.s));
                check(mon_nm, "pos_floor", int'(pos_floor), int'(mon_e.pos));
                check(mon_nm, "moving", int'(moving), int'(mon_e.mov));
                check(mon_nm, "fault", int'(fault), int'(mon_e.flt));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        step(1, STOP, 0, S0, 1, 0, 0, "rst_a");
        step(1, STOP, 0, S0, 1, 0, 0, "rst_b");
        // 1: UP from floor 1, moving on cycles 1-4, s2 on cycle 4
        step(0, UP,   0, S0, 1, 1, 0, "t1_c1");
        step(0, UP,   0, S0, 1, 1, 0, "t1_c2");
        step(0, UP,   0, S0, 1, 1, 0, "t1_c3");
        step(0, UP,   0, S2, 2, 1, 0, "t1_c4_arrive");
        step(0, STOP, 0, S0, 2, 0, 0, "t1_idle");
        // 2: UP 2, STOP 3, UP 2 -> s3 seven cycles after start
        step(0, UP,   0, S0, 2, 1, 0, "t2_up1");
        step(0, UP,   0, S0, 2, 1, 0, "t2_up2");
        step(0, STOP, 0, S0, 2, 0, 0, "t2_stall1");
        step(0, STOP, 0, S0, 2, 0, 0, "t2_stall2");
        step(0, STOP, 0, S0, 2, 0, 0, "t2_stall3");
        step(0, UP,   0, S0, 2, 1, 0, "t2_up3");
        step(0, UP,   0, S3, 3, 1, 0, "t2_arrive");
        step(0, STOP, 0, S0, 3, 0, 0, "t2_idle");
        // 3: departure + one DOWN cycle (timer=1), then UP mirrors to 2
        step(0, DN,   0, S0, 3, 1, 0, "t3_depart");
        step(0, DN,   0, S0, 3, 1, 0, "t3_down");
        step(0, UP,   0, S0, 3, 1, 0, "t3_reverse");
        step(0, UP,   0, S3, 3, 1, 0, "t3_rearrive");
        step(0, STOP, 0, S0, 3, 0, 0, "t3_idle");
        // reversal right at departure returns immediately
        step(0, DN,   0, S0, 3, 1, 0, "rv0_depart");
        step(0, UP,   0, S3, 3, 1, 0, "rv0_arrive");
        step(0, STOP, 0, S0, 3, 0, 0, "rv0_idle");
        // overtravel is not triggered when idle at top; walk down to floor 1
        step(0, DN,   0, S0, 3, 1, 0, "dn32_c1");
        step(0, DN,   0, S0, 3, 1, 0, "dn32_c2");
        step(0, DN,   0, S0, 3, 1, 0, "dn32_c3");
        step(0, DN,   0, S2, 2, 1, 0, "dn32_arrive");
        step(0, DN,   0, S0, 2, 1, 0, "dn21_c1");
        step(0, DN,   0, S0, 2, 1, 0, "dn21_c2");
        step(0, DN,   0, S0, 2, 1, 0, "dn21_c3");
        step(0, DN,   0, S1, 1, 1, 0, "dn21_arrive");
        step(0, STOP, 0, S0, 1, 0, 0, "dn21_idle");
        // 4: DOWN at floor 1 faults; later UP ignored
        step(0, DN,   0, S0, 1, 0, 1, "t4_overtravel");
        step(0, UP,   0, S0, 1, 0, 1, "t4_up_ignored");
        step(0, UP,   0, S0, 1, 0, 1, "t4_still_fault");
        // 5: door open with UP faults; rst clears
        step(1, STOP, 0, S0, 1, 0, 0, "t5_rst");
        step(0, STOP, 1, S0, 1, 0, 0, "t5_door_stop_ok");
        step(0, UP,   1, S0, 1, 0, 1, "t5_door_up");
        step(0, STOP, 0, S0, 1, 0, 1, "t5_sticky");
        step(1, STOP, 0, S0, 1, 0, 0, "t5_rst_clear");
        // illegal command code
        step(0, ILL,  0, S0, 1, 0, 1, "ill_code");
        step(1, STOP, 0, S0, 1, 0, 0, "ill_rst");
        // door opening mid-travel
        step(0, UP,   0, S0, 1, 1, 0, "dm_depart");
        step(0, UP,   1, S0, 1, 0, 1, "dm_door_up");
        step(1, STOP, 0, S0, 1, 0, 0, "dm_rst");
        // 6: rst with timer=2 toward floor 2
        step(0, UP,   0, S0, 1, 1, 0, "t6_c1");
        step(0, UP,   0, S0, 1, 1, 0, "t6_c2");
        step(0, UP,   0, S0, 1, 1, 0, "t6_c3");
        step(1, UP,   0, S0, 1, 0, 0, "t6_rst");
        step(0, STOP, 0, S0, 1, 0, 0, "t6_no_s2_a");
        step(0, STOP, 0, S0, 1, 0, 0, "t6_no_s2_b");
        @(negedge clk);
        #1;
        check("scoreboard", "pending", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
